// File: rtl/bp_pkg.sv
// bp_pkg: shared BTB entry type, counter constants and PC index/tag helpers for the branch predictor.
package bp_pkg;
  typedef struct packed {
    logic        valid;
    logic        isJump;
    logic [29:0] tag;
    logic [31:0] target;
  } btbEntry_t;
  function automatic int cntWeakT(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int cntWeakNT(input int w);
    return (1 << (w - 1)) - 1;
  endfunction
  function automatic int cntMax(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic logic [31:0] pcIdx(input logic [31:0] pc, input int idxW);
    return (pc >> 2) & ((32'd1 << idxW) - 32'd1);
  endfunction
  function automatic logic [29:0] pcTag(input logic [31:0] pc, input int idxW);
    return 30'(pc >> (idxW + 2));
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: IF-stage lookup, EX-stage resolve/redirect and stats bus of the branch predictor.
interface branch_predictor_if #(parameter int STAT_W = 32);
  logic              if_valid;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_is_ctrl;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic [STAT_W-1:0] stat_lookups;
  logic [STAT_W-1:0] stat_mispred;
  modport master (
    output if_valid, if_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc, stat_lookups, stat_mispred
  );
  modport slave (
    input  if_valid, if_pc, upd_valid, upd_pc, upd_is_ctrl, upd_is_jump, upd_taken,
           upd_target, upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc, stat_lookups, stat_mispred
  );
endinterface

// File: rtl/bp_sat_counter.sv
// bp_sat_counter: next value of a saturating counter (set-to-max, increment or decrement, no wrap).
module bp_sat_counter import bp_pkg::*; #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cur,
  input  logic             inc,
  input  logic             dec,
  input  logic             setMax,
  output logic [CNT_W-1:0] nxt
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(cntMax(CNT_W));
  always_comb nxt = setMax ? MAX :
                    (inc && cur != MAX) ? cur + 1'b1 :
                    (dec && cur != '0) ? cur - 1'b1 : cur;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + saturating-counter predictor with EX-stage redirect and stats.
// Define BP_GSHARE_EN to XOR global history into the counter-table index.
module branch_predictor import bp_pkg::*; #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 4,
  parameter int STAT_W  = 32
) (
  input logic clk,
  input logic rst,
  branch_predictor_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] WEAK_T  = CNT_W'(cntWeakT(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(cntWeakNT(CNT_W));
  localparam logic [CNT_W-1:0] MAX     = CNT_W'(cntMax(CNT_W));
  btbEntry_t         btb [ENTRIES];
  logic [CNT_W-1:0]  cnt [ENTRIES];
  logic [IDX_W-1:0]  lkIdx, upIdx, lkCIdx, upCIdx, histPad;
  logic [29:0]       lkTag, upTag;
  logic              lkHit, upHit;
  logic [CNT_W-1:0]  upCntNext;
  logic [STAT_W-1:0] lookups, mispred;
`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] ghr;
  // history only advances on resolved conditional branches, never speculatively
  always_ff @(posedge clk)
    if (rst) ghr <= '0;
    else if (bus.upd_valid && bus.upd_is_ctrl && !bus.upd_is_jump) ghr <= HIST_W'({ghr, bus.upd_taken});
  assign histPad = IDX_W'(ghr) << (IDX_W - HIST_W);
`else
  assign histPad = '0;
`endif
  always_comb begin
    lkIdx  = IDX_W'(pcIdx(bus.if_pc, IDX_W));
    upIdx  = IDX_W'(pcIdx(bus.upd_pc, IDX_W));
    lkTag  = pcTag(bus.if_pc, IDX_W);
    upTag  = pcTag(bus.upd_pc, IDX_W);
    lkCIdx = lkIdx ^ histPad;
    upCIdx = upIdx ^ histPad;
    lkHit  = btb[lkIdx].valid && btb[lkIdx].tag == lkTag;
    upHit  = btb[upIdx].valid && btb[upIdx].tag == upTag;
  end
  bp_sat_counter #(.CNT_W(CNT_W)) uCnt (
    .cur(cnt[upCIdx]),
    .inc(bus.upd_taken),
    .dec(!bus.upd_taken),
    .setMax(bus.upd_is_jump),
    .nxt(upCntNext)
  );
  assign bus.pred_taken  = !rst && lkHit && (btb[lkIdx].isJump || cnt[lkCIdx][CNT_W-1]);
  assign bus.pred_target = bus.pred_taken ? btb[lkIdx].target : bus.if_pc + 32'd4;
  assign bus.redirect    = !rst && bus.upd_valid && (bus.upd_taken != bus.upd_pred_taken ||
                           (bus.upd_taken && bus.upd_target != bus.upd_pred_target));
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target : bus.upd_pc + 32'd4;
  assign bus.stat_lookups = lookups;
  assign bus.stat_mispred = mispred;
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i] <= '0;
        cnt[i] <= WEAK_NT;
      end
    end else if (bus.upd_valid) begin
      if (bus.upd_is_ctrl && upHit) begin
        btb[upIdx].target <= bus.upd_target;
        cnt[upCIdx]       <= upCntNext;
      end else if (bus.upd_is_ctrl && bus.upd_taken) begin
        btb[upIdx] <= '{valid: 1'b1, isJump: bus.upd_is_jump, tag: upTag, target: bus.upd_target};
        cnt[upCIdx] <= bus.upd_is_jump ? MAX : WEAK_T;
      end else if (!bus.upd_is_ctrl && upHit) begin
        btb[upIdx].valid <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (rst) begin
      lookups <= '0;
      mispred <= '0;
    end else begin
      if (bus.if_valid && !(&lookups)) lookups <= lookups + 1'b1;
      if (bus.redirect && !(&mispred)) mispred <= mispred + 1'b1;
    end
endmodule
